// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM encodings and widths for the UART transmit path
package uart_tx_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int BAUD_W = 13;

  typedef enum logic [2:0] {
    UART_TX_IDLE   = 3'd0,
    UART_TX_START  = 3'd1,
    UART_TX_DATA   = 3'd2,
    UART_TX_PARITY = 3'd3,
    UART_TX_STOP   = 3'd4
  } tx_state_t;

  // even sense keeps the total count of ones even, odd sense makes it odd
  function automatic logic parity_bit(input logic acc, input logic even);
    return acc ^ ~even;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversample tick generator, a down-counter that reloads on zero or on demand
module uart_baud_gen
  import uart_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [BAUD_W-1:0] val,
  output logic              tick
);

  logic [BAUD_W-1:0] cnt;

  assign tick = cnt == '0;

  // count down, reloading on every tick and whenever a frame starts
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (load || tick) ? val : cnt - 1'b1;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: byte buffer plus start/data/parity/stop serialiser; UART_TX_FIFO_EN selects a FIFO, otherwise a single holding register
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW = 2
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              tx_data_reg_wr,
  input  logic [7:0]        tx_data,
  input  logic [BAUD_W-1:0] baud_val,
  input  logic              data_bits,
  input  logic              parity_en,
  input  logic              parity_odd0_even1,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              tx
);

  logic              push, pop, empty, full, tick, bit_end;
  logic [7:0]        head, shift;
  tx_state_t         state;
  logic [3:0]        tcnt;
  logic [2:0]        bidx;
  logic              par, f_bits8, f_par_en, f_even;
  logic [BAUD_W-1:0] f_baud;

  // full is the pre-edge value, so a same-cycle pop never rescues a write
  assign push = tx_data_reg_wr && !full;
  assign bit_end = tick && tcnt == 4'(OVERSAMPLE - 1);
  assign pop = !empty && (state == UART_TX_IDLE || (state == UART_TX_STOP && bit_end));
  assign tx_ready = !full;
  assign tx_busy = state != UART_TX_IDLE || !empty;

`ifdef UART_TX_FIFO_EN
  logic [7:0]       mem [FIFO_DEPTH];
  logic [FIFO_AW:0] wptr, rptr;

  assign empty = wptr == rptr;
  assign full = wptr[FIFO_AW] != rptr[FIFO_AW] && wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0];
  assign head = mem[rptr[FIFO_AW-1:0]];

  // storage needs no reset; emptiness is tracked by the pointers
  always_ff @(posedge ACLK)
    if (push) mem[wptr[FIFO_AW-1:0]] <= tx_data;

  // pointers carry an extra wrap bit to tell full from empty
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
`else
  logic [7:0]  hold;
  logic        hold_v;
  logic [31:0] unused_fifo_cfg;

  // depth parameters only size the FIFO build
  assign unused_fifo_cfg = FIFO_DEPTH + FIFO_AW;
  assign empty = !hold_v;
  assign full = hold_v;
  assign head = hold;

  // single-entry buffer; push and pop are mutually exclusive at depth one
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      hold <= '0;
      hold_v <= 1'b0;
    end else begin
      if (push) hold <= tx_data;
      hold_v <= push ? 1'b1 : pop ? 1'b0 : hold_v;
    end
`endif

  // a new frame restarts the divisor with the live setting so it is tick-aligned from its start edge
  uart_baud_gen u_baud (
    .clk  (ACLK),
    .rst_n(ARESETn),
    .load (pop),
    .val  (pop ? baud_val : f_baud),
    .tick (tick)
  );

  // frame sequencer; tx is registered from the current state so the line never glitches
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      state <= UART_TX_IDLE;
      tx <= 1'b1;
      shift <= '0;
      tcnt <= '0;
      bidx <= '0;
      par <= 1'b0;
      f_bits8 <= 1'b0;
      f_par_en <= 1'b0;
      f_even <= 1'b0;
      f_baud <= '0;
    end else begin
      tx <= state == UART_TX_START ? 1'b0 :
            state == UART_TX_DATA ? shift[0] :
            state == UART_TX_PARITY ? parity_bit(par, f_even) : 1'b1;
      if (pop) begin
        state <= UART_TX_START;
        shift <= head;
        tcnt <= '0;
        bidx <= '0;
        par <= 1'b0;
        f_bits8 <= data_bits;
        f_par_en <= parity_en;
        f_even <= parity_odd0_even1;
        f_baud <= baud_val;
      end else begin
        if (tick) tcnt <= tcnt + 1'b1;
        case (state)
          UART_TX_IDLE: ;
          UART_TX_START: if (bit_end) state <= UART_TX_DATA;
          UART_TX_DATA:
            if (bit_end) begin
              shift <= shift >> 1;
              par <= par ^ shift[0];
              bidx <= bidx + 1'b1;
              if (bidx == (f_bits8 ? 3'd7 : 3'd6)) state <= f_par_en ? UART_TX_PARITY : UART_TX_STOP;
            end
          UART_TX_PARITY: if (bit_end) state <= UART_TX_STOP;
          UART_TX_STOP: if (bit_end) state <= UART_TX_IDLE;
          default: state <= UART_TX_IDLE;
        endcase
      end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed, table-driven check of uart_tx line timing, buffering, config latch and reset
module tb_uart_tx;

`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        wr = 1'b0;
  logic [7:0]  data = '0;
  logic [12:0] baud = '0;
  logic        bits8 = 1'b1, pen = 1'b0, even = 1'b0;
  logic        ready, busy, tx;
  int          errors = 0, checks = 0;

  typedef struct {
    logic [7:0]  data;
    logic [12:0] baud;
    logic        bits8, pen, even;
    logic [11:0] pat;
    int          n;
  } vec_t;

  vec_t v[7];

  uart_tx #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .tx_data_reg_wr(wr), .tx_data(data),
    .baud_val(baud), .data_bits(bits8), .parity_en(pen), .parity_odd0_even1(even),
    .tx_ready(ready), .tx_busy(busy), .tx(tx)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(posedge ACLK); #1 data = b; wr = 1'b1;
    @(posedge ACLK); #1 wr = 1'b0;
  endtask

  // samples every cycle of n line bits of len cycles, skipping cycles already elapsed
  task automatic check_line(input string name, input logic [11:0] pat, input int n, input int len, input int skip);
    int bad, seen;
    for (int i = 0; i < n; i++) begin
      bad = 0;
      seen = 0;
      for (int c = 0; c < len; c++)
        if (i * len + c >= skip) begin
          @(posedge ACLK); #1;
          seen++;
          if (tx !== pat[i]) bad++;
        end
      if (seen > 0) chk($sformatf("%s bit%0d wrong cycles", name, i), bad, 0);
    end
  endtask

  task automatic apply_vec(input int k, input string name);
    data = v[k].data; baud = v[k].baud; bits8 = v[k].bits8; pen = v[k].pen; even = v[k].even;
    write_byte(v[k].data);
    @(posedge ACLK); #1;
    chk({name, " tx before start"}, int'(tx), 1);
    chk({name, " busy in frame"}, int'(busy), 1);
    check_line(name, v[k].pat, v[k].n, 16 * (int'(v[k].baud) + 1), 0);
    chk({name, " busy after"}, int'(busy), 0);
    chk({name, " tx after"}, int'(tx), 1);
  endtask

  task automatic quiet(input string name, input int cycles);
    int low;
    low = 0;
    repeat (cycles) begin
      @(posedge ACLK); #1;
      if (tx !== 1'b1) low++;
    end
    chk({name, " tx low cycles"}, low, 0);
  endtask

  initial begin
    logic [7:0] bursts[5];
    logic [7:0] exp_bytes[$];
    int bad_r, bad_b;
    v[0] = '{8'hA5, 13'd0, 1'b1, 1'b0, 1'b0, 12'h34A, 10};
    v[1] = '{8'hD3, 13'd2, 1'b0, 1'b1, 1'b1, 12'h2A6, 10};
    v[2] = '{8'hD3, 13'd2, 1'b0, 1'b1, 1'b0, 12'h3A6, 10};
    v[3] = '{8'h00, 13'd1, 1'b1, 1'b1, 1'b1, 12'h400, 11};
    v[4] = '{8'hFF, 13'd0, 1'b1, 1'b1, 1'b0, 12'h7FE, 11};
    v[5] = '{8'h80, 13'd0, 1'b0, 1'b0, 1'b0, 12'h100, 9};
    v[6] = '{8'h7F, 13'd0, 1'b0, 1'b1, 1'b0, 12'h2FE, 10};
    bursts = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    repeat (3) @(posedge ACLK);
    #1;
    chk("reset tx", int'(tx), 1);
    chk("reset ready", int'(ready), 1);
    chk("reset busy", int'(busy), 0);
    ARESETn = 1'b1;
    bad_r = 0;
    bad_b = 0;
    repeat (1000) begin
      @(posedge ACLK); #1;
      if (ready !== 1'b1) bad_r++;
      if (busy !== 1'b0) bad_b++;
    end
    chk("idle ready bad cycles", bad_r, 0);
    chk("idle busy bad cycles", bad_b, 0);
    quiet("idle", 10);

    for (int k = 0; k < 7; k++) apply_vec(k, $sformatf("vec%0d", k));

    // burst of five consecutive writes from idle
    baud = 13'd0; bits8 = 1'b1; pen = 1'b0;
    @(posedge ACLK); #1 data = bursts[0]; wr = 1'b1;
    for (int i = 1; i < 5; i++) begin
      @(posedge ACLK); #1;
      if (i == 4) chk("burst ready after 4 writes", int'(ready), DEPTH > 1 ? 1 : 0);
      data = bursts[i];
    end
    @(posedge ACLK); #1 wr = 1'b0;
    chk("burst ready after 5 writes", int'(ready), 0);
    if (DEPTH > 1) exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    else exp_bytes = '{8'h11, 8'h33};
    for (int f = 0; f < exp_bytes.size(); f++)
      check_line($sformatf("burst f%0d", f), {3'b001, exp_bytes[f], 1'b0}, 10, 16, f == 0 ? 3 : 0);
    chk("burst busy after", int'(busy), 0);
    quiet("burst extra frame", 300);

    // config change mid-frame only affects the following frame
    write_byte(8'h55);
    @(posedge ACLK); #1;
    chk("cfg tx before start", int'(tx), 1);
    data = 8'h0F; wr = 1'b1;
    fork
      begin
        @(posedge ACLK); #1 wr = 1'b0;
        repeat (50) @(posedge ACLK);
        #1 pen = 1'b1; even = 1'b1; baud = 13'd1;
      end
      begin
        check_line("cfg f1", 12'h2AA, 10, 16, 0);
        check_line("cfg f2", 12'h41E, 11, 32, 0);
      end
    join
    chk("cfg busy after", int'(busy), 0);

    // reset in the middle of the data bits with another byte queued
    baud = 13'd0; pen = 1'b0; even = 1'b0;
    write_byte(8'hC3);
    write_byte(8'h5A);
    repeat (30) @(posedge ACLK);
    #2 ARESETn = 1'b0;
    #1;
    chk("midreset tx", int'(tx), 1);
    chk("midreset ready", int'(ready), 1);
    chk("midreset busy", int'(busy), 0);
    @(posedge ACLK); #1 ARESETn = 1'b1;
    quiet("post reset", 300);
    chk("post reset busy", int'(busy), 0);
    apply_vec(0, "post reset vec0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmit engine of the UART, directly downstream of the UART register block.
- Accepts bytes from register-block writes into a small TX FIFO and serialises them as start / data (LSB first) / optional parity / stop frames on the `tx` pin.
- Bit timing comes from `baud_val` using a 16x oversample tick, matching the RX side.
- Drives `tx_ready` back to the status register.

Parameters:
- FIFO_DEPTH, 4, number of TX FIFO entries; power of two, ≥2.
- FIFO_AW, 2, FIFO pointer width; must equal log2(FIFO_DEPTH).

Ports:
- ACLK  input  1  clock; all logic on the rising edge.
- ARESETn  input  1  asynchronous active-low reset.
- tx_data_reg_wr  input  1  one-cycle write strobe; push `tx_data` into the FIFO.
- tx_data  input  8  byte to transmit.
- baud_val  input  13  divisor; oversample tick period = `baud_val`+1 ACLK cycles.
- data_bits  input  1  0 = 7 data bits, 1 = 8 data bits.
- parity_en  input  1  1 = append parity bit.
- parity_odd0_even1  input  1  parity sense: 0 odd, 1 even.
- tx_ready  output  1  1 = FIFO not full; may write.
- tx_busy  output  1  1 = FSM not IDLE or FIFO not empty.
- tx  output  1  serial line; idle high.

Behaviour:
- Reset: `tx`=1, `tx_ready`=1, `tx_busy`=0, FIFO empty (pointers 0), FSM in IDLE, baud counter 0. Reset asserted mid-frame aborts immediately and `tx` returns to 1.
- FIFO push: on `tx_data_reg_wr` when not full.
  - Write while full is dropped silently. "Full" is the pre-edge value, so a simultaneous pop does not rescue the write.
  - Bits above the FIFO width are ignored.
- FIFO pointers: wrap modulo FIFO_DEPTH; an extra wrap bit distinguishes full from empty.
- Baud tick: a 13-bit down-counter reloads `baud_val` and pulses `tick` when it reaches 0.
  - The counter reloads on the IDLE→START transition, so frames are tick-aligned from their start edge.
  - 1 bit = 16 ticks = 16*(`baud_val`+1) ACLK cycles.
- Config latch: on pop, `data_bits`, `parity_en`, `parity_odd0_even1` and `baud_val` are latched into frame registers. Changes mid-frame affect only the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx`=1. If FIFO not empty: pop into the shift register, latch config, go to START. `tx` falls on the edge after the pop, so `tx` is low 2 ACLK edges after the write edge when starting from empty/idle.
  - START: `tx`=0 for 16 ticks → DATA.
  - DATA: `tx`=shift[0]; shift right every 16 ticks. After 7 or 8 bits (per latched `data_bits`), go to PARITY if parity enabled, else STOP.
  - PARITY: `tx`=XOR(data bits sent) XOR ~`parity_odd0_even1`, for 16 ticks → STOP. Even parity gives an even total count of ones; odd gives an odd total.
  - STOP: `tx`=1 for 16 ticks. Then, if the FIFO is not empty, pop and go directly to START (back-to-back frames with no idle gap); else go to IDLE.
- 7-bit mode: transmits `tx_data`[6:0]; bit 7 is ignored, including for parity.
- `tx` is driven from a flop (glitch-free).
- `baud_val`=0 is legal and gives the fastest rate: 16 clocks per bit.

Optional Feature:
- Macro: `UART_TX_FIFO_EN`.
- Defined: FIFO of FIFO_DEPTH entries as above.
- Undefined: a single holding register replaces the FIFO.
  - `tx_ready` = holding register empty.
  - Push/pop/drop rules are identical with depth 1.
  - The FIFO_DEPTH and FIFO_AW parameters are ignored.

Decomposition:
- Shared package/header (top_defines): FSM state encodings (UART_TX_IDLE..UART_TX_STOP, 3 bits), `OVERSAMPLE` = 16, `BAUD_W` = 13.
- One sub-module: `uart_baud_gen` (counter + reload + tick). It will be shared with `uart_rx`.

Test Plan:
- Reset, then no writes → `tx`=1, `tx_ready`=1, `tx_busy`=0 for 1000 cycles.
- `baud_val`=0, 8N1, write 0xA5 → `tx` low exactly 2 edges after the write. Line sequence is 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; 160 cycles total, then `tx_busy`=0.
- `baud_val`=2, 7-bit, even parity, write 0xD3 → data 1,1,0,0,1,0,1, parity 0, stop 1; each bit 48 cycles. Repeat with odd parity → parity bit 1.
- FIFO_DEPTH=4: write 5 bytes in consecutive cycles while FSM idle.
  - `tx_ready` drops once 4 bytes are buffered (the first is popped).
  - Exactly 5 frames if space allows, else the full-time write is dropped. Check the frame count against the scoreboard.
  - Frames are back-to-back with no idle gap between stop and start.
- Change `parity_en` and `baud_val` mid-frame → current frame unchanged; the next frame uses the new settings.
- Assert ARESETn mid-DATA → `tx`=1 immediately, FIFO empty, and a new write afterwards transmits cleanly.
